// File: rtl/wb_master_if.sv
// Wishbone classic bus bundle shared by initiator and target ends.
interface wb_bus_t #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] sel;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_m2s;
    logic [DATA_WIDTH-1:0]   dat_s2m;
    logic                    ack;
    logic                    err;

    modport master (
        output cyc, stb, we, sel, adr, dat_m2s,
        input  dat_s2m, ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_m2s,
        output dat_s2m, ack, err
    );
endinterface

// File: rtl/wb_master.sv
// Single-outstanding Wishbone classic initiator with valid/ready request and response channels.
// Optional bus timeout abort is built when WB_MASTER_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request, req_ready_o high
// BUS   | cyc/stb asserted, bus outputs frozen until ack/err (or timeout)
// RESP  | response presented, held until resp_ready_i
module wb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_we_i,
    input  logic [DATA_WIDTH/8-1:0] req_sel_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    resp_err_o,
    output logic                    resp_timeout_o,
    wb_bus_t.master                 wb_bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

    assign req_ready_o = (state == IDLE);

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_flag;

    assign resp_timeout_o = tmo_flag;
`else
    logic unused_tmo;

    assign unused_tmo     = (TIMEOUT_CYCLES > 0);
    assign resp_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            resp_valid_o   <= 1'b0;
            resp_rdata_o   <= '0;
            resp_err_o     <= 1'b0;
            wb_bus.cyc     <= 1'b0;
            wb_bus.stb     <= 1'b0;
            wb_bus.we      <= 1'b0;
            wb_bus.sel     <= '0;
            wb_bus.adr     <= '0;
            wb_bus.dat_m2s <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt        <= '0;
            tmo_flag       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        wb_bus.cyc     <= 1'b1;
                        wb_bus.stb     <= 1'b1;
                        wb_bus.we      <= req_we_i;
                        wb_bus.sel     <= req_sel_i;
                        wb_bus.adr     <= req_addr_i;
                        wb_bus.dat_m2s <= req_wdata_i;
`ifdef WB_MASTER_TIMEOUT_EN
                        tmo_cnt        <= '0;
`endif
                        state          <= BUS;
                    end
                end

                BUS: begin
                    // err has priority over ack when both arrive together
                    if (wb_bus.err) begin
                        wb_bus.cyc   <= 1'b0;
                        wb_bus.stb   <= 1'b0;
                        resp_rdata_o <= '0;
                        resp_err_o   <= 1'b1;
                        resp_valid_o <= 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
                        tmo_flag     <= 1'b0;
`endif
                        state        <= RESP;
                    end else if (wb_bus.ack) begin
                        wb_bus.cyc   <= 1'b0;
                        wb_bus.stb   <= 1'b0;
                        resp_rdata_o <= wb_bus.we ? '0 : wb_bus.dat_s2m;
                        resp_err_o   <= 1'b0;
                        resp_valid_o <= 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
                        tmo_flag     <= 1'b0;
`endif
                        state        <= RESP;
                    end
`ifdef WB_MASTER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        wb_bus.cyc   <= 1'b0;
                        wb_bus.stb   <= 1'b0;
                        resp_rdata_o <= '0;
                        resp_err_o   <= 1'b1;
                        resp_valid_o <= 1'b1;
                        tmo_flag     <= 1'b1;
                        state        <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end

                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master.sv
// Directed self-checking bench for wb_master; the slave side is driven by hand from each test.
module tb_wb_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        req_we_i = 1'b0;
    logic [3:0]  req_sel_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        resp_timeout_o;

    int vectors = 0;
    int miscompares = 0;

    wb_bus_t #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wb_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_we_i       (req_we_i),
        .req_sel_i      (req_sel_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .resp_timeout_o (resp_timeout_o),
        .wb_bus         (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive_req(input logic [31:0] addr, input logic we,
                             input logic [3:0] sel, input logic [31:0] wdata);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_we_i    = we;
        req_sel_i   = sel;
        req_wdata_i = wdata;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        bus.ack = 1'b0; bus.err = 1'b0; bus.dat_s2m = '0;
        repeat (2) @(negedge clk_i);
        if (req_ready_o !== 1'b1) begin $display("FAIL rst_req_ready: got %b want 1", req_ready_o); miscompares++; end vectors++;
        if (resp_valid_o !== 1'b0) begin $display("FAIL rst_resp_valid: got %b want 0", resp_valid_o); miscompares++; end vectors++;
        if (resp_rdata_o !== 32'h0) begin $display("FAIL rst_rdata: got %h want 0", resp_rdata_o); miscompares++; end vectors++;
        if (resp_err_o !== 1'b0 || resp_timeout_o !== 1'b0) begin $display("FAIL rst_err_tmo: got %b%b want 00", resp_err_o, resp_timeout_o); miscompares++; end vectors++;
        if (bus.cyc !== 1'b0 || bus.stb !== 1'b0 || bus.we !== 1'b0) begin $display("FAIL rst_cyc_stb_we: got %b%b%b want 000", bus.cyc, bus.stb, bus.we); miscompares++; end vectors++;
        if (bus.sel !== 4'h0 || bus.adr !== 32'h0 || bus.dat_m2s !== 32'h0) begin $display("FAIL rst_sel_adr_dat: got %h %h %h want 0 0 0", bus.sel, bus.adr, bus.dat_m2s); miscompares++; end vectors++;
        rst_i = 1'b0;
    endtask

    task automatic test_read_zero_wait;
        drive_req(32'h10, 1'b0, 4'hF, 32'h0);
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        if (bus.cyc !== 1'b1 || bus.stb !== 1'b1) begin $display("FAIL rd_cyc_on: got %b%b want 11", bus.cyc, bus.stb); miscompares++; end vectors++;
        if (bus.adr !== 32'h10 || bus.we !== 1'b0 || bus.sel !== 4'hF) begin $display("FAIL rd_bus_fields: got %h %b %h want 10 0 f", bus.adr, bus.we, bus.sel); miscompares++; end vectors++;
        if (resp_valid_o !== 1'b0) begin $display("FAIL rd_early_valid: got %b want 0", resp_valid_o); miscompares++; end vectors++;
        bus.ack = 1'b1; bus.dat_s2m = 32'hDEADBEEF;
        @(negedge clk_i);
        bus.ack = 1'b0;
        if (bus.cyc !== 1'b0 || bus.stb !== 1'b0) begin $display("FAIL rd_cyc_off: got %b%b want 00", bus.cyc, bus.stb); miscompares++; end vectors++;
        if (resp_valid_o !== 1'b1) begin $display("FAIL rd_resp_valid: got %b want 1", resp_valid_o); miscompares++; end vectors++;
        if (resp_rdata_o !== 32'hDEADBEEF || resp_err_o !== 1'b0) begin $display("FAIL rd_resp_data: got %h err %b want deadbeef err 0", resp_rdata_o, resp_err_o); miscompares++; end vectors++;
        if (req_ready_o !== 1'b0) begin $display("FAIL rd_ready_in_resp: got %b want 0", req_ready_o); miscompares++; end vectors++;
        @(negedge clk_i);
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin $display("FAIL rd_back_idle: got valid %b ready %b want 0 1", resp_valid_o, req_ready_o); miscompares++; end vectors++;
    endtask

    task automatic test_write_wait_states;
        drive_req(32'h24, 1'b1, 4'h3, 32'h12345678);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_addr_i = 32'h99; req_wdata_i = 32'hFFFFFFFF; req_sel_i = 4'hC; req_we_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.cyc !== 1'b1 || bus.stb !== 1'b1 || bus.we !== 1'b1) begin $display("FAIL wr_ctl_cycle%0d: got %b%b%b want 111", i, bus.cyc, bus.stb, bus.we); miscompares++; end vectors++;
            if (bus.adr !== 32'h24 || bus.dat_m2s !== 32'h12345678 || bus.sel !== 4'h3) begin $display("FAIL wr_hold_cycle%0d: got %h %h %h want 24 12345678 3", i, bus.adr, bus.dat_m2s, bus.sel); miscompares++; end vectors++;
            if (i == 3) begin bus.ack = 1'b1; bus.dat_s2m = 32'hCAFEF00D; end
            @(negedge clk_i);
        end
        bus.ack = 1'b0;
        if (bus.cyc !== 1'b0 || resp_valid_o !== 1'b1) begin $display("FAIL wr_resp: got cyc %b valid %b want 0 1", bus.cyc, resp_valid_o); miscompares++; end vectors++;
        if (resp_rdata_o !== 32'h0 || resp_err_o !== 1'b0) begin $display("FAIL wr_resp_data: got %h err %b want 0 err 0", resp_rdata_o, resp_err_o); miscompares++; end vectors++;
        @(negedge clk_i);
        if (resp_valid_o !== 1'b0) begin $display("FAIL wr_done: got %b want 0", resp_valid_o); miscompares++; end vectors++;
    endtask

    task automatic test_err_and_spurious;
        drive_req(32'h30, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        bus.ack = 1'b1; bus.err = 1'b1; bus.dat_s2m = 32'hFFFFFFFF;
        @(negedge clk_i);
        bus.ack = 1'b0; bus.err = 1'b0;
        if (resp_valid_o !== 1'b1 || resp_err_o !== 1'b1) begin $display("FAIL err_resp: got valid %b err %b want 1 1", resp_valid_o, resp_err_o); miscompares++; end vectors++;
        if (resp_rdata_o !== 32'h0 || resp_timeout_o !== 1'b0) begin $display("FAIL err_data: got %h tmo %b want 0 0", resp_rdata_o, resp_timeout_o); miscompares++; end vectors++;
        if (bus.cyc !== 1'b0) begin $display("FAIL err_cyc: got %b want 0", bus.cyc); miscompares++; end vectors++;
        @(negedge clk_i);
        bus.ack = 1'b1; bus.dat_s2m = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (resp_valid_o !== 1'b0 || bus.cyc !== 1'b0 || req_ready_o !== 1'b1) begin $display("FAIL spurious_ack%0d: got valid %b cyc %b ready %b want 0 0 1", i, resp_valid_o, bus.cyc, req_ready_o); miscompares++; end vectors++;
        end
        bus.ack = 1'b0;
    endtask

    task automatic test_backpressure;
        resp_ready_i = 1'b0;
        drive_req(32'h40, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        drive_req(32'h50, 1'b0, 4'h1, 32'h0);
        bus.ack = 1'b1; bus.dat_s2m = 32'h0BADF00D;
        @(negedge clk_i);
        bus.ack = 1'b0; bus.dat_s2m = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h0BADF00D) begin $display("FAIL bp_hold%0d: got valid %b data %h want 1 0badf00d", i, resp_valid_o, resp_rdata_o); miscompares++; end vectors++;
            if (req_ready_o !== 1'b0 || bus.cyc !== 1'b0) begin $display("FAIL bp_ready%0d: got ready %b cyc %b want 0 0", i, req_ready_o, bus.cyc); miscompares++; end vectors++;
            if (i == 4) resp_ready_i = 1'b1;
            @(negedge clk_i);
        end
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || bus.cyc !== 1'b0) begin $display("FAIL bp_after_hs: got valid %b ready %b cyc %b want 0 1 0", resp_valid_o, req_ready_o, bus.cyc); miscompares++; end vectors++;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        if (bus.cyc !== 1'b1 || bus.adr !== 32'h50 || bus.sel !== 4'h1) begin $display("FAIL bp_second_req: got cyc %b adr %h sel %h want 1 50 1", bus.cyc, bus.adr, bus.sel); miscompares++; end vectors++;
        bus.ack = 1'b1; bus.dat_s2m = 32'h00C0FFEE;
        @(negedge clk_i);
        bus.ack = 1'b0;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h00C0FFEE) begin $display("FAIL bp_second_resp: got valid %b data %h want 1 00c0ffee", resp_valid_o, resp_rdata_o); miscompares++; end vectors++;
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_bus;
        drive_req(32'h60, 1'b1, 4'hF, 32'hA5A5A5A5);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        if (bus.cyc !== 1'b1) begin $display("FAIL mrst_first_bus: got %b want 1", bus.cyc); miscompares++; end vectors++;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        if (bus.cyc !== 1'b0 || bus.stb !== 1'b0) begin $display("FAIL mrst_cyc_stb: got %b%b want 00", bus.cyc, bus.stb); miscompares++; end vectors++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin $display("FAIL mrst_resp_ready: got valid %b ready %b want 0 1", resp_valid_o, req_ready_o); miscompares++; end vectors++;
        bus.ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            bus.ack = 1'b0;
            if (resp_valid_o !== 1'b0 || bus.cyc !== 1'b0) begin $display("FAIL mrst_no_resp%0d: got valid %b cyc %b want 0 0", i, resp_valid_o, bus.cyc); miscompares++; end vectors++;
        end
    endtask

`ifdef WB_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        drive_req(32'h70, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.cyc !== 1'b1 || resp_valid_o !== 1'b0) begin $display("FAIL tmo_bus%0d: got cyc %b valid %b want 1 0", i, bus.cyc, resp_valid_o); miscompares++; end vectors++;
            @(negedge clk_i);
        end
        if (bus.cyc !== 1'b0 || resp_valid_o !== 1'b1) begin $display("FAIL tmo_abort: got cyc %b valid %b want 0 1", bus.cyc, resp_valid_o); miscompares++; end vectors++;
        if (resp_err_o !== 1'b1 || resp_timeout_o !== 1'b1 || resp_rdata_o !== 32'h0) begin $display("FAIL tmo_resp: got err %b tmo %b data %h want 1 1 0", resp_err_o, resp_timeout_o, resp_rdata_o); miscompares++; end vectors++;
        @(negedge clk_i);
        drive_req(32'h74, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.cyc !== 1'b1) begin $display("FAIL tmo_ack_bus%0d: got %b want 1", i, bus.cyc); miscompares++; end vectors++;
            if (i == 7) begin bus.ack = 1'b1; bus.dat_s2m = 32'h5A5A5A5A; end
            @(negedge clk_i);
        end
        bus.ack = 1'b0;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h5A5A5A5A) begin $display("FAIL tmo_ack_resp: got valid %b data %h want 1 5a5a5a5a", resp_valid_o, resp_rdata_o); miscompares++; end vectors++;
        if (resp_err_o !== 1'b0 || resp_timeout_o !== 1'b0) begin $display("FAIL tmo_ack_flags: got err %b tmo %b want 0 0", resp_err_o, resp_timeout_o); miscompares++; end vectors++;
        @(negedge clk_i);
    endtask
`else
    task automatic test_no_timeout;
        drive_req(32'h70, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.cyc !== 1'b1 || resp_valid_o !== 1'b0) begin $display("FAIL nto_wait%0d: got cyc %b valid %b want 1 0", i, bus.cyc, resp_valid_o); miscompares++; end vectors++;
            @(negedge clk_i);
        end
        bus.ack = 1'b1; bus.dat_s2m = 32'h5A5A5A5A;
        @(negedge clk_i);
        bus.ack = 1'b0;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h5A5A5A5A) begin $display("FAIL nto_resp: got valid %b data %h want 1 5a5a5a5a", resp_valid_o, resp_rdata_o); miscompares++; end vectors++;
        if (resp_err_o !== 1'b0 || resp_timeout_o !== 1'b0) begin $display("FAIL nto_flags: got err %b tmo %b want 0 0", resp_err_o, resp_timeout_o); miscompares++; end vectors++;
        @(negedge clk_i);
    endtask
`endif

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait_states();
        test_err_and_spurious();
        test_backpressure();
        test_reset_mid_bus();
`ifdef WB_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
